alu_mul_seq: RTL and testbench
==============================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameter: WIDTH, 16, data width of operands, product and ALU data ports.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to multiply a by b; sampled only in IDLE.
REQ-005 a  input  WIDTH  multiplicand, captured on accepted start.
REQ-006 b  input  WIDTH  multiplier, captured on accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse, high only in DONE.
REQ-009 product  output  WIDTH  registered result, low WIDTH bits of a*b.
REQ-010 alu_x, alu_y  output  WIDTH  operands driven to the shared Hack ALU.
REQ-011 alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits.
REQ-012 alu_out  input  WIDTH  ALU result, combinational from driven operands/controls.

Function
REQ-013 The block SHALL compute the product by shift-and-add, performing every addition through the external ALU and containing no adder/multiplier of its own for acc or mc.
REQ-014 Internal registers: state, acc (WIDTH), mc (WIDTH), mp (WIDTH), product (WIDTH).
REQ-015 States SHALL be IDLE, EVAL, ADD, DBL, DONE.
REQ-016 IDLE: if start=1 at a rising edge, acc<=0, mc<=a, mp<=b, state<=EVAL; else remain.
REQ-017 EVAL: mp==0 -> DONE and product<=acc; else mp[0]=1 -> ADD; else -> DBL.
REQ-018 ADD: alu_x=acc, alu_y=mc, controls zx=0 nx=0 zy=0 ny=0 f=1 no=0 (x+y); acc<=alu_out; -> DBL.
REQ-019 DBL: alu_x=mc, alu_y=mc, controls x+y as in ADD; mc<=alu_out; mp<=mp>>1 (zero-fill); -> EVAL.
REQ-020 DONE: done=1 for exactly one cycle; -> IDLE unconditionally; start in DONE ignored.
REQ-021 In IDLE, EVAL, DONE: alu_x=0, alu_y=0, all six ALU control bits=0.
REQ-022 ALU outputs SHALL be combinational decodes of state and registers (no extra latency); alu_out consumed same cycle.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; carries out of acc and mc discarded; result equals low WIDTH bits of two's-complement product for signed or unsigned operands.
REQ-024 start while busy=1 SHALL be ignored; a, b changes after acceptance SHALL not affect the result.
REQ-025 Latency: start accepted at edge T -> done high in cycle T+2+2k+p, where k = index of highest set bit of b plus 1 (k=0 for b=0), p = popcount(b); max 50 cycles for WIDTH=16.
REQ-026 product SHALL change only on EVAL->DONE transition and hold its value through IDLE until the next completion.
REQ-027 Back-to-back: start asserted in the cycle after DONE (IDLE) SHALL be accepted.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, acc=mc=mp=product=0, busy=0, done=0, ALU outputs per REQ-021, regardless of clock.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no done pulse; product reads 0.
REQ-030 After rst_n deasserts, start SHALL be sampled from the first rising edge at which rst_n=1.

Verification
REQ-031 a=7, b=0, start pulse at T -> busy=1 T+1..T+2, done=1 at T+2 only, product=0.
REQ-032 a=5, b=3 -> done at T+8, product=15; ADD cycles show alu_x=acc, alu_y=mc, alu_f=1, other controls 0.
REQ-033 a=0xFFFF (-1), b=0xFFFF -> done at T+50, product=0x0001; a=0x0100, b=0x0100 -> product=0x0000 (wrap).
REQ-034 a=3, b=0x8000 -> done at T+35, product=0x8000; start re-pulsed during busy with a=9, b=9 -> ignored, single done.
REQ-035 a=6, b=7 started; rst_n low mid-ADD -> all outputs at reset values asynchronously, no done; after release, a=6, b=7 -> product=42.
REQ-036 Two operations back-to-back (start in IDLE cycle after done) -> both complete; product holds first result until second done.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that performs every addition through
// an external, shared Hack ALU. The result is the low WIDTH bits of a*b.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, a, b         request to multiply; operands captured when start is accepted in IDLE
//   busy, done          busy in every state except IDLE; done is a one-cycle pulse in DONE
//   product             registered result, held until the next completion
//   alu_x, alu_y        operands driven to the shared ALU
//   alu_zx..alu_no      Hack ALU control bits (x+y, or all zero when the ALU is not in use)
//   alu_out             combinational ALU result, consumed in the same cycle
module alu_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EVAL = 3'd1;
  localparam logic [2:0] S_ADD  = 3'd2;
  localparam logic [2:0] S_DBL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mc, mc_nxt;
  logic [WIDTH-1:0] mp, mp_nxt;
  logic [WIDTH-1:0] product_nxt;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      mc      <= mc_nxt;
      mp      <= mp_nxt;
      product <= product_nxt;
    end
  end

  // Next-state, datapath updates and ALU/status decode
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    mc_nxt      = mc;
    mp_nxt      = mp;
    product_nxt = product;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    alu_x       = '0;
    alu_y       = '0;
    alu_zx      = 1'b0;
    alu_nx      = 1'b0;
    alu_zy      = 1'b0;
    alu_ny      = 1'b0;
    alu_f       = 1'b0;
    alu_no      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          mc_nxt    = a;
          mp_nxt    = b;
          state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        if (mp == '0) begin
          product_nxt = acc;
          state_nxt   = S_DONE;
        end else if (mp[0]) begin
          state_nxt = S_ADD;
        end else begin
          state_nxt = S_DBL;
        end
      end
      S_ADD: begin
        // acc + mc through the ALU (f=1 selects x+y)
        alu_x     = acc;
        alu_y     = mc;
        alu_f     = 1'b1;
        acc_nxt   = alu_out;
        state_nxt = S_DBL;
      end
      S_DBL: begin
        // mc + mc doubles the multiplicand; the multiplier shifts right in step
        alu_x     = mc;
        alu_y     = mc;
        alu_f     = 1'b1;
        mc_nxt    = alu_out;
        mp_nxt    = mp >> 1;
        state_nxt = S_EVAL;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: provides a Hack ALU, drives multiply requests,
// tracks a cycle model of the expected ALU/status outputs and checks
// product and latency through a scoreboard.
module tb_alu_mul_seq;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] product;
  logic [W-1:0] alu_x, alu_y, alu_out;
  logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
    .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out)
  );

  // Hack ALU
  logic [W-1:0] hx0, hx1, hy0, hy1, hr;
  always_comb begin
    hx0     = alu_zx ? '0 : alu_x;
    hx1     = alu_nx ? ~hx0 : hx0;
    hy0     = alu_zy ? '0 : alu_y;
    hy1     = alu_ny ? ~hy0 : hy0;
    hr      = alu_f ? W'(hx1 + hy1) : (hx1 & hy1);
    alu_out = alu_no ? ~hr : hr;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] prod;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] last_prod;

  localparam int M_IDLE = 0, M_EVAL = 1, M_ADD = 2, M_DBL = 3, M_DONE = 4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_prod"}, 32'(product), 32'd0);
    check({tag, "_alux"}, 32'(alu_x), 32'd0);
    check({tag, "_aluy"}, 32'(alu_y), 32'd0);
    check({tag, "_ctl"}, 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'd0);
  endtask

  // Runs one multiply; abort_at >= 0 asserts reset at that cycle instead of completing.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input bit repulse, input int abort_at);
    exp_t         e;
    int           k, p, cyc, m_st;
    bit           got;
    logic [W-1:0] m_acc, m_mc, m_mp, ex_x, ex_y;
    logic         ex_f;
    k = 0;
    p = 0;
    for (int i = 0; i < int'(W); i++) begin
      if (op_b[i]) begin
        k = i + 1;
        p++;
      end
    end
    e.prod = W'(op_a * op_b);
    e.lat  = 1 + 2 * k + p;
    sb.push_back(e);

    @(negedge clk);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    @(posedge clk);
    m_st  = M_EVAL;
    m_acc = '0;
    m_mc  = op_a;
    m_mp  = op_b;
    cyc   = 0;
    got   = 1'b0;
    while (!got && cyc < 80) begin
      @(negedge clk);
      // Operand changes and retried starts after acceptance must have no effect
      if (repulse && cyc >= 3 && cyc <= 5) begin
        start = 1'b1;
        a     = 16'd9;
        b     = 16'd9;
      end else begin
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
      end
      ex_x = '0;
      ex_y = '0;
      ex_f = 1'b0;
      if (m_st == M_ADD) begin
        ex_x = m_acc; ex_y = m_mc; ex_f = 1'b1;
      end else if (m_st == M_DBL) begin
        ex_x = m_mc; ex_y = m_mc; ex_f = 1'b1;
      end
      check("alu_x", 32'(alu_x), 32'(ex_x));
      check("alu_y", 32'(alu_y), 32'(ex_y));
      check("alu_ctl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}),
            32'({4'b0000, ex_f, 1'b0}));
      check("busy", 32'(busy), 32'(m_st != M_IDLE));
      check("done", 32'(done), 32'(m_st == M_DONE));
      if (done) begin
        got = 1'b1;
        e   = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.lat));
        check("product", 32'(product), 32'(e.prod));
        last_prod = e.prod;
      end else begin
        check("prod_hold", 32'(product), 32'(last_prod));
      end
      if (cyc == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        sb.delete();
        last_prod = '0;
        start     = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("no_done_after_rst", 32'(done), 32'd0);
          check("prod_after_rst", 32'(product), 32'd0);
        end
        return;
      end
      // Advance the cycle model
      case (m_st)
        M_EVAL: m_st = (m_mp == '0) ? M_DONE : (m_mp[0] ? M_ADD : M_DBL);
        M_ADD: begin
          m_acc = W'(m_acc + m_mc);
          m_st  = M_DBL;
        end
        M_DBL: begin
          m_mc = W'(m_mc + m_mc);
          m_mp = m_mp >> 1;
          m_st = M_EVAL;
        end
        default: m_st = M_IDLE;
      endcase
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!got) begin
      check("timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    last_prod = '0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd7, 16'd0, 1'b0, -1);
    // Single done only: the next cycle is IDLE
    @(negedge clk);
    check("post_done_idle", 32'({busy, done}), 32'd0);
    run_op(16'd5, 16'd3, 1'b0, -1);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, -1);
    run_op(16'h0100, 16'h0100, 1'b0, -1);
    run_op(16'd3, 16'h8000, 1'b1, -1);
    @(negedge clk);
    check("repulse_single_done", 32'({busy, done}), 32'd0);
    run_op(16'd6, 16'd7, 1'b0, 1);
    run_op(16'd6, 16'd7, 1'b0, -1);
    // Back-to-back: second start lands in the IDLE cycle right after DONE
    run_op(16'd12, 16'd11, 1'b0, -1);
    run_op(16'hABCD, 16'h1234, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
